// File: rtl/out_bcd_conv.sv
// out_bcd_conv: serial shift-add-3 binary-to-BCD converter for the CPU out port.
// Define OUT_BCD_SIGNED_EN to treat the input as two's complement (magnitude + neg flag).
module out_bcd_conv #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  valid,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q, work_d, last_in_q, last_in_d, mag;
    logic [BW-1:0]         scr_q, scr_d, bcd_q, bcd_d, adj;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pend_q, pend_d, valid_q, valid_d;
`ifdef OUT_BCD_SIGNED_EN
    logic sign_q, sign_d, neg_q, neg_d;
    assign mag = in[DATA_WIDTH-1] ? -in : in;
    assign neg = neg_q;
`else
    assign mag = in;
    assign neg = 1'b0;
`endif
    assign bcd   = bcd_q;
    assign valid = valid_q;
    assign busy  = state_q != IDLE;
    // Add 3 to every scratch digit >= 5 so the following shift carries correctly into the next digit.
    always_comb begin
        adj = scr_q;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k+:4] = scr_q[4*k+:4] >= 4'd5 ? scr_q[4*k+:4] + 4'd3 : scr_q[4*k+:4];
    end
    // Next-state and datapath: capture on input change, shift DATA_WIDTH times, publish once.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        last_in_d = last_in_q;
        pend_d    = pend_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
`ifdef OUT_BCD_SIGNED_EN
        sign_d    = sign_q;
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE: if (pend_q || in != last_in_q) begin
                work_d    = mag;
                last_in_d = in;
                pend_d    = 1'b0;
                scr_d     = '0;
                cnt_d     = CW'(DATA_WIDTH);
                state_d   = SHIFT;
`ifdef OUT_BCD_SIGNED_EN
                sign_d    = in[DATA_WIDTH-1];
`endif
            end
            SHIFT: begin
                scr_d   = {adj[BW-2:0], work_q[DATA_WIDTH-1]};
                work_d  = {work_q[DATA_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == CW'(1) ? DONE : SHIFT;
            end
            DONE: begin
                bcd_d   = scr_q;
                valid_d = 1'b1;
                state_d = IDLE;
`ifdef OUT_BCD_SIGNED_EN
                neg_d   = sign_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    // State register; reset leaves a pending conversion so the current input is converted after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            last_in_q <= '0;
            pend_q    <= 1'b1;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
`ifdef OUT_BCD_SIGNED_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            last_in_q <= last_in_d;
            pend_q    <= pend_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
`ifdef OUT_BCD_SIGNED_EN
            sign_q    <= sign_d;
            neg_q     <= neg_d;
`endif
        end
    end
endmodule

// File: tb/tb_out_bcd_conv.sv
// tb_out_bcd_conv: directed checks of out_bcd_conv latency, conversion values, input tracking and reset abort.
module tb_out_bcd_conv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = '0;
    logic [19:0] bcd;
    logic        neg, valid, busy;
    int          n_checks = 0;
    int          n_fails = 0;

    out_bcd_conv dut (.clk(clk), .rst_n(rst_n), .in(in), .bcd(bcd), .neg(neg), .valid(valid), .busy(busy));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        if (!valid) check("valid_timeout", 32'(valid), 32'd1);
    endtask

    initial begin
        int n, pulses, e1, e2;
        logic [19:0] b1, b2;
        logic        early_valid;
        // reset state
        in = 16'd12345;
        tick();
        tick();
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_neg", 32'(neg), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        // release mid-cycle: next edge is capture edge 0
        rst_n = 1'b1;
        tick();
        check("e0_busy", 32'(busy), 32'h1);
        check("e0_valid", 32'(valid), 32'h0);
        early_valid = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            early_valid |= valid;
            if (e == 16) check("e16_busy", 32'(busy), 32'h1);
        end
        check("no_early_valid", 32'(early_valid), 32'h0);
        check("no_early_bcd", 32'(bcd), 32'h0);
        tick();
        check("e17_valid", 32'(valid), 32'h1);
        check("e17_bcd", 32'(bcd), 32'h12345);
        tick();
        check("e18_valid", 32'(valid), 32'h0);
        check("e18_busy", 32'(busy), 32'h0);
        // all ones
        in = 16'hFFFF;
        wait_valid(n);
        check("ffff_latency", 32'(n), 32'd18);
`ifdef OUT_BCD_SIGNED_EN
        check("ffff_bcd", 32'(bcd), 32'h00001);
        check("ffff_neg", 32'(neg), 32'h1);
`else
        check("ffff_bcd", 32'(bcd), 32'h65535);
        check("ffff_neg", 32'(neg), 32'h0);
`endif
        // most negative / 32768
        tick();
        in = 16'h8000;
        wait_valid(n);
        check("8000_bcd", 32'(bcd), 32'h32768);
`ifdef OUT_BCD_SIGNED_EN
        check("8000_neg", 32'(neg), 32'h1);
`else
        check("8000_neg", 32'(neg), 32'h0);
`endif
        tick();
        in = 16'd0;
        wait_valid(n);
        check("zero_bcd", 32'(bcd), 32'h0);
        check("zero_neg", 32'(neg), 32'h0);
        tick();
        // input change mid-conversion
        in = 16'd100;
        pulses = 0; e1 = -1; e2 = -1; b1 = '0; b2 = '0;
        tick();
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (e == 5) in = 16'd200;
            if (valid) begin
                pulses++;
                if (pulses == 1) begin e1 = e; b1 = bcd; end
                if (pulses == 2) begin e2 = e; b2 = bcd; end
            end
        end
        check("chg_pulses", 32'(pulses), 32'd2);
        check("chg_first_bcd", 32'(b1), 32'h00100);
        check("chg_first_edge", 32'(e1), 32'd17);
        check("chg_second_bcd", 32'(b2), 32'h00200);
        check("chg_second_edge", 32'(e2), 32'd35);
        // reset abort mid-conversion
        in = 16'd999;
        early_valid = 1'b0;
        tick();
        for (int e = 1; e <= 8; e++) begin
            tick();
            early_valid |= valid;
        end
        rst_n = 1'b0;
        #1;
        check("abort_bcd", 32'(bcd), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        tick();
        early_valid |= valid;
        tick();
        early_valid |= valid;
        check("abort_no_valid", 32'(early_valid), 32'h0);
        rst_n = 1'b1;
        wait_valid(n);
        check("abort_latency", 32'(n), 32'd18);
        check("abort_bcd_after", 32'(bcd), 32'h00999);
        // idle hold
        pulses = 0;
        n = 0;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (valid) pulses++;
            if (busy) n++;
        end
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_busy", 32'(n), 32'd0);
        check("idle_bcd_held", 32'(bcd), 32'h00999);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
